// File: rtl/eh2_ifu_rvc_pack_if.sv
// eh2_ifu_rvc_pack_if: instruction-in / packed-word-out handshake bundle for the RVC packer.
interface eh2_ifu_rvc_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush_req;
    logic        flush_ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    modport master (output in_valid, in_instr, flush_req, out_ready,
                    input  in_ready, flush_ack, out_valid, out_data);
    modport slave  (input  in_valid, in_instr, flush_req, out_ready,
                    output in_ready, flush_ack, out_valid, out_data);
endinterface

// File: rtl/eh2_ifu_rvc_pack.sv
// eh2_ifu_rvc_pack: RV32 -> RVC compressor and little-endian 16/32-bit parcel packer.
// RV_RVC_PACK_EBREAK_EN: when defined, ebreak is compressed to c.ebreak.
module eh2_ifu_rvc_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    eh2_ifu_rvc_pack_if.slave bus,
    output logic [CNT_W-1:0] cmp_cnt
);
    logic [31:0] instr;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm_i, imm_s;
    logic        fits, is_addi, is_add;
    logic        c_nop, c_addi, c_li, c_mv, c_add, c_lw, c_sw, c_ebrk, is_c;
    logic [15:0] parcel, hold;
    logic        full, acc, do_flush;

    assign instr = bus.in_instr;
    assign op    = instr[6:0];
    assign rd    = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign f7    = instr[31:25];
    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign fits  = (&imm_i[11:5]) | ~(|imm_i[11:5]);

    assign is_addi = op == 7'h13 && f3 == 3'd0;
    assign is_add  = op == 7'h33 && f3 == 3'd0 && f7 == 7'd0;
    assign c_nop   = instr == 32'h0000_0013;
    assign c_addi  = is_addi && rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && fits;
    assign c_li    = is_addi && rs1 == 5'd0 && rd != 5'd0 && fits;
    assign c_mv    = is_add && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0;
    assign c_add   = is_add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0;
    assign c_lw    = op == 7'h03 && f3 == 3'd2 && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                     imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0;
    assign c_sw    = op == 7'h23 && f3 == 3'd2 && rs1[4:3] == 2'b01 && rs2[4:3] == 2'b01 &&
                     imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0;
`ifdef RV_RVC_PACK_EBREAK_EN
    assign c_ebrk  = instr == 32'h0010_0073;
`else
    assign c_ebrk  = 1'b0;
`endif
    assign is_c = c_nop | c_addi | c_li | c_mv | c_add | c_lw | c_sw | c_ebrk;

    always_comb begin
        parcel = c_nop  ? 16'h0001 :
                 c_addi ? {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01} :
                 c_li   ? {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01} :
                 c_mv   ? {4'b1000, rd, rs2, 2'b10} :
                 c_add  ? {4'b1001, rd, rs2, 2'b10} :
                 c_lw   ? {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00} :
                 c_sw   ? {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00} :
                 c_ebrk ? 16'h9002 : 16'h0000;
    end

    assign bus.in_ready = !bus.out_valid | bus.out_ready;
    assign acc          = bus.in_valid & bus.in_ready;
    // flush_ack blocks re-service while the requester is still dropping flush_req
    assign do_flush     = bus.flush_req & !bus.in_valid & bus.in_ready & !bus.flush_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= 32'd0;
            bus.flush_ack <= 1'b0;
            cmp_cnt       <= '0;
            hold          <= 16'd0;
            full          <= 1'b0;
        end else begin
            bus.flush_ack <= do_flush;
            if (acc) begin
                if (is_c && cmp_cnt != '1) cmp_cnt <= cmp_cnt + 1'b1;
                if (!is_c) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= full ? {instr[15:0], hold} : instr;
                    hold          <= instr[31:16];
                end else if (full) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= {parcel, hold};
                    full          <= 1'b0;
                end else begin
                    bus.out_valid <= 1'b0;
                    hold          <= parcel;
                    full          <= 1'b1;
                end
            end else if (do_flush) begin
                bus.out_valid <= full;
                if (full) bus.out_data <= {16'h0001, hold};
                full <= 1'b0;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_eh2_ifu_rvc_pack.sv
// tb_eh2_ifu_rvc_pack: directed-vector bench for the RVC packer, incl. a CNT_W=2 instance.
module tb_eh2_ifu_rvc_pack;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    int checks = 0;
    int errors = 0;

    eh2_ifu_rvc_pack_if bif ();
    eh2_ifu_rvc_pack_if bif2 ();

    eh2_ifu_rvc_pack #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bif), .cmp_cnt(cnt));
    eh2_ifu_rvc_pack #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bif2), .cmp_cnt(cnt2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        bif.in_valid = 0; bif.in_instr = 0; bif.flush_req = 0; bif.out_ready = 1;
        bif2.in_valid = 0; bif2.in_instr = 0; bif2.flush_req = 0; bif2.out_ready = 1;
        cyc(); cyc();
        rst = 0;
        chk("rst_ov", 32'(bif.out_valid), 32'd0);
        chk("rst_od", bif.out_data, 32'd0);
        chk("rst_ack", 32'(bif.flush_ack), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_rdy", 32'(bif.in_ready), 32'd1);

        // c.addi then c.mv pack into one word
        bif.in_valid = 1; bif.in_instr = 32'h0015_0513; cyc();
        chk("half_ov", 32'(bif.out_valid), 32'd0);
        bif.in_instr = 32'h00B0_0533; cyc();
        bif.in_valid = 0;
        chk("pk1_ov", 32'(bif.out_valid), 32'd1);
        chk("pk1_od", bif.out_data, 32'h852E_0505);
        chk("pk1_cnt", 32'(cnt), 32'd2);
        cyc();
        chk("pk1_drain", 32'(bif.out_valid), 32'd0);

        // 32-bit passthrough with empty hold
        bif.in_valid = 1; bif.in_instr = 32'h1234_52B7; cyc();
        bif.in_valid = 0;
        chk("lui_od", bif.out_data, 32'h1234_52B7);
        chk("lui_cnt", 32'(cnt), 32'd2);
        cyc();

        // c.lw then lui straddling, then flush
        bif.in_valid = 1; bif.in_instr = 32'h0044_A403; cyc();
        chk("lw_ov", 32'(bif.out_valid), 32'd0);
        bif.in_instr = 32'h1234_52B7; cyc();
        bif.in_valid = 0; bif.flush_req = 1;
        chk("strad_od", bif.out_data, 32'h52B7_40C0);
        chk("strad_cnt", 32'(cnt), 32'd3);
        cyc();
        chk("fl_ack", 32'(bif.flush_ack), 32'd1);
        chk("fl_ov", 32'(bif.out_valid), 32'd1);
        chk("fl_od", bif.out_data, 32'h0001_1234);
        bif.flush_req = 0; cyc();
        chk("fl_ack_once", 32'(bif.flush_ack), 32'd0);
        chk("fl_drain", 32'(bif.out_valid), 32'd0);

        // c.li + c.add, then c.sw + c.nop
        bif.in_valid = 1; bif.in_instr = 32'hFFF0_0293; cyc();
        bif.in_instr = 32'h00B5_0533; cyc();
        chk("li_add_od", bif.out_data, 32'h952E_52FD);
        bif.in_instr = 32'h0094_2423; cyc();
        bif.in_instr = 32'h0000_0013; cyc();
        chk("sw_nop_od", bif.out_data, 32'h0001_C404);
        chk("sw_nop_cnt", 32'(cnt), 32'd7);
        // imm out of c.addi range
        bif.in_instr = 32'h0205_0513; cyc();
        chk("imm32_od", bif.out_data, 32'h0205_0513);
        chk("imm32_cnt", 32'(cnt), 32'd7);
`ifndef RV_RVC_PACK_EBREAK_EN
        bif.in_instr = 32'h0010_0073; cyc();
        chk("ebrk_od", bif.out_data, 32'h0010_0073);
        chk("ebrk_cnt", 32'(cnt), 32'd7);
`endif
        bif.in_valid = 0; cyc();

        // backpressure
        bif.out_ready = 0;
        bif.in_valid = 1; bif.in_instr = 32'h1234_52B7; cyc();
        bif.in_instr = 32'hCAFE_00B7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdy", 32'(bif.in_ready), 32'd0);
            chk("bp_od", bif.out_data, 32'h1234_52B7);
            cyc();
        end
        bif.out_ready = 1; cyc();
        bif.in_valid = 0;
        chk("bp_next", bif.out_data, 32'hCAFE_00B7);
        chk("bp_nv", 32'(bif.out_valid), 32'd1);
        cyc();
        chk("bp_drain", 32'(bif.out_valid), 32'd0);

        // reset with H=F and pending output
        bif.out_ready = 0;
        bif.in_valid = 1; bif.in_instr = 32'h0044_A403; cyc();
        bif.in_instr = 32'h1234_52B7; cyc();
        bif.in_valid = 0;
        chk("pre_rst_ov", 32'(bif.out_valid), 32'd1);
        rst = 1; cyc();
        rst = 0;
        chk("mid_rst_ov", 32'(bif.out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        bif.out_ready = 1; bif.flush_req = 1; cyc();
        chk("e_fl_ack", 32'(bif.flush_ack), 32'd1);
        chk("e_fl_ov", 32'(bif.out_valid), 32'd0);
        bif.flush_req = 0; cyc();
        chk("e_fl_once", 32'(bif.flush_ack), 32'd0);

        // saturation with CNT_W=2
        chk("sat_start", 32'(cnt2), 32'd0);
        bif2.in_valid = 1; bif2.in_instr = 32'h0015_0513;
        for (int i = 0; i < 5; i++) cyc();
        bif2.in_valid = 0;
        chk("sat_cnt", 32'(cnt2), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
